// File: rtl/ddr3_req_bridge_if.sv
// Request/response port of the MCU side plus the MIG 7-series app port, bundled.
// The slave modport is the bridge's view; master is the MCU + MIG environment.
interface ddr3_req_bridge_if #(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128
);
  logic                        init_calib_complete;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [31:0]                 req_addr;
  logic [3:0]                  req_be;
  logic [31:0]                 req_wdata;

  logic                        rsp_valid;
  logic [31:0]                 rsp_rdata;
  logic                        rsp_err;

  logic [APP_ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic                        app_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_wdf_data;
  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                        app_wdf_wren;
  logic                        app_wdf_end;
  logic                        app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_rd_data;
  logic                        app_rd_data_valid;
  logic                        app_rd_data_end;

  modport slave (
    input  init_calib_complete,
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output app_addr, app_cmd, app_en,
    input  app_rdy,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport master (
    output init_calib_complete,
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  app_addr, app_cmd, app_en,
    output app_rdy,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_wdf_rdy,
    output app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr3_req_bridge.sv
// Single-outstanding bridge turning 32-bit word reads/writes into single-beat MIG app commands,
// with lane placement, write masking and a handshake timeout that reports an error response.
module ddr3_req_bridge #(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic              ui_clk,
  input logic              sys_rst_n,
  ddr3_req_bridge_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned MaskW = APP_DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StWr, StRdCmd, StRdWait, StResp} state_e;

  state_e                    state_q;
  logic                      live_q;
  logic                      cmd_done_q;
  logic                      data_done_q;
  logic                      pend_drop_q;
  logic [1:0]                lane_q;
  logic [CntW-1:0]           cnt_q;

  logic                      app_en_q;
  logic [2:0]                app_cmd_q;
  logic [APP_ADDR_WIDTH-1:0] app_addr_q;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data_q;
  logic [MaskW-1:0]          app_wdf_mask_q;
  logic                      app_wdf_wren_q;
  logic                      rsp_valid_q;
  logic                      rsp_err_q;
  logic [31:0]               rsp_rdata_q;

  logic                      req_ready;
  logic                      accept;
  logic                      cmd_hs;
  logic                      dat_hs;
  logic                      timeout;
  logic [CntW-1:0]           cnt_inc;
  logic [MaskW-1:0]          wr_mask;
  logic [31:0]               rd_word;
  logic                      unused_sig;

  // live_q keeps req_ready low while reset is held and for the reset cycle itself.
  assign req_ready = live_q & (state_q == StIdle) & bus_io.init_calib_complete & ~pend_drop_q;
  assign accept    = bus_io.req_valid & req_ready;
  assign cmd_hs    = app_en_q & bus_io.app_rdy;
  assign dat_hs    = app_wdf_wren_q & bus_io.app_wdf_rdy;
  assign cnt_inc   = cnt_q + 1'b1;
  assign timeout   = (cnt_inc == CntW'(TIMEOUT_CYCLES));
  assign rd_word   = bus_io.app_rd_data[{lane_q, 5'b00000} +: 32];

  assign unused_sig = ^{bus_io.req_addr, bus_io.app_rd_data_end};

  always_comb begin
    wr_mask = '1;
    wr_mask[{bus_io.req_addr[3:2], 2'b00} +: 4] = ~bus_io.req_be;
  end

  always_ff @(posedge ui_clk) begin
    if (!sys_rst_n) begin
      state_q        <= StIdle;
      live_q         <= 1'b0;
      cmd_done_q     <= 1'b0;
      data_done_q    <= 1'b0;
      pend_drop_q    <= 1'b0;
      lane_q         <= '0;
      cnt_q          <= '0;
      app_en_q       <= 1'b0;
      app_cmd_q      <= '0;
      app_addr_q     <= '0;
      app_wdf_data_q <= '0;
      app_wdf_mask_q <= '0;
      app_wdf_wren_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      live_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      // A read abandoned after its command was accepted still owes us one beat.
      if (pend_drop_q && bus_io.app_rd_data_valid) pend_drop_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q       <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            lane_q      <= bus_io.req_addr[3:2];
            app_addr_q  <= {bus_io.req_addr[APP_ADDR_WIDTH:4], 3'b000};
            app_en_q    <= 1'b1;
            if (bus_io.req_we) begin
              app_cmd_q      <= 3'b000;
              app_wdf_wren_q <= 1'b1;
              app_wdf_data_q <= {4{bus_io.req_wdata}};
              app_wdf_mask_q <= wr_mask;
              state_q        <= StWr;
            end else begin
              app_cmd_q <= 3'b001;
              state_q   <= StRdCmd;
            end
          end
        end

        StWr: begin
          cnt_q <= cnt_inc;
          if (cmd_hs) begin
            app_en_q   <= 1'b0;
            cmd_done_q <= 1'b1;
          end
          if (dat_hs) begin
            app_wdf_wren_q <= 1'b0;
            data_done_q    <= 1'b1;
          end
          if ((cmd_done_q || cmd_hs) && (data_done_q || dat_hs)) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else if (timeout) begin
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            state_q        <= StResp;
            rsp_valid_q    <= 1'b1;
            rsp_err_q      <= 1'b1;
            rsp_rdata_q    <= '0;
          end
        end

        StRdCmd: begin
          cnt_q <= cnt_inc;
          if (cmd_hs) app_en_q <= 1'b0;
          if (timeout) begin
            app_en_q    <= 1'b0;
            pend_drop_q <= cmd_hs;
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else if (cmd_hs) begin
            state_q <= StRdWait;
          end
        end

        StRdWait: begin
          cnt_q <= cnt_inc;
          if (bus_io.app_rd_data_valid) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= rd_word;
          end else if (timeout) begin
            pend_drop_q <= 1'b1;
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end

        StResp: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.req_ready    = req_ready;
  assign bus_io.rsp_valid    = rsp_valid_q;
  assign bus_io.rsp_err      = rsp_err_q;
  assign bus_io.rsp_rdata    = rsp_rdata_q;
  assign bus_io.app_en       = app_en_q;
  assign bus_io.app_cmd      = app_cmd_q;
  assign bus_io.app_addr     = app_addr_q;
  assign bus_io.app_wdf_data = app_wdf_data_q;
  assign bus_io.app_wdf_mask = app_wdf_mask_q;
  assign bus_io.app_wdf_wren = app_wdf_wren_q;
  assign bus_io.app_wdf_end  = app_wdf_wren_q;

endmodule
